// File: rtl/spi_arbiter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spi_arbiter_seq
//  Description : Shares one SPI byte engine between two requesters (port 0:
//                CPU, port 1: boot/DMA loader). Arbitrates whole transactions
//                round-robin without preemption, frames each transaction with
//                cs_n, and sequences every byte through the engine:
//                accept byte -> fire engine -> wait completion -> return byte.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CS_SETUP : clk cycles cs_n is low before the first eng_send (1..15)
//    CS_GAP   : clk cycles cs_n stays high after a transaction before the
//               next grant can be issued (1..15)
//  Ports
//    clk, rst                 : clock, asynchronous active-high reset
//    req0/1                   : level transaction request, held until done
//    wvalid0/1, wdata0/1,
//    wlast0/1                 : byte to send, last-byte marker
//    wready0/1                : 1-cycle pulse, byte accepted
//    rvalid0/1, rdata         : 1-cycle pulse qualifying the shared rdata
//    grant0/1                 : port owns the bus from grant until done
//    done0/1                  : 1-cycle pulse, transaction closed, cs_n high
//    cs_n                     : SPI chip select, active-low
//    eng_send, eng_tx         : start a byte in the engine / byte to send
//    eng_done, eng_rx         : engine finished a byte / byte received
// ============================================================================
module spi_arbiter_seq #(
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GAP   = 3
) (
    input  logic       clk,
    input  logic       rst,
    // requester port 0 (CPU)
    input  logic       req0,
    input  logic       wvalid0,
    input  logic [7:0] wdata0,
    input  logic       wlast0,
    output logic       wready0,
    output logic       rvalid0,
    output logic       grant0,
    output logic       done0,
    // requester port 1 (boot/DMA loader)
    input  logic       req1,
    input  logic       wvalid1,
    input  logic [7:0] wdata1,
    input  logic       wlast1,
    output logic       wready1,
    output logic       rvalid1,
    output logic       grant1,
    output logic       done1,
    // shared read data
    output logic [7:0] rdata,
    // SPI framing
    output logic       cs_n,
    // byte engine handshake
    output logic       eng_send,
    output logic [7:0] eng_tx,
    input  logic       eng_done,
    input  logic [7:0] eng_rx
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_setup_load = 4'(CS_SETUP - 1);
    localparam logic [3:0] c_gap_load   = 4'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q,      state_d;
    logic        owner_q,      owner_d;       // 0: port 0, 1: port 1
    logic        last_owner_q, last_owner_d;  // round-robin history
    logic [3:0]  cnt_q,        cnt_d;         // setup / gap countdown
    logic        last_f_q,     last_f_d;      // byte in flight is the final one
    logic [7:0]  eng_tx_q,     eng_tx_d;
    logic [7:0]  rdata_q,      rdata_d;
    logic        grant0_q,     grant0_d;
    logic        grant1_q,     grant1_d;
    logic        cs_n_q,       cs_n_d;
    logic        rvalid0_q,    rvalid0_d;
    logic        rvalid1_q,    rvalid1_d;
    logic        done0_q,      done0_d;
    logic        done1_q,      done1_d;

    // ------------------------------------------------------------------------
    // Owner-side write channel selection; the non-owner is never looked at.
    // ------------------------------------------------------------------------
    logic       w_own_wvalid;
    logic [7:0] w_own_wdata;
    logic       w_own_wlast;
    logic       w_issue_fire;
    logic       w_pick;

    assign w_own_wvalid = owner_q ? wvalid1 : wvalid0;
    assign w_own_wdata  = owner_q ? wdata1  : wdata0;
    assign w_own_wlast  = owner_q ? wlast1  : wlast0;

    // The byte is accepted and the engine fired in the same cycle the owner's
    // wvalid is seen in ISSUE, so these strobes are decoded from state.
    assign w_issue_fire = (state_q == S_ISSUE) && w_own_wvalid;

    // Round-robin pick: a lone request wins outright, a tie goes to the port
    // that did not own the bus last.
    assign w_pick = (req0 && req1) ? ~last_owner_q : req1;

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        last_f_d     = last_f_q;
        eng_tx_d     = eng_tx_q;
        rdata_d      = rdata_q;
        grant0_d     = grant0_q;
        grant1_d     = grant1_q;
        cs_n_d       = cs_n_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d      = w_pick;
                    last_owner_d = w_pick;
                    grant0_d     = ~w_pick;
                    grant1_d     = w_pick;
                    cs_n_d       = 1'b0;
                    cnt_d        = c_setup_load;
                    state_d      = S_SETUP;
                end
            end

            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_ISSUE: begin
                if (w_own_wvalid) begin
                    eng_tx_d = w_own_wdata;
                    last_f_d = w_own_wlast;
                    state_d  = S_WAIT;
                end
            end

            S_WAIT: begin
                // eng_done is only meaningful here; elsewhere it is ignored.
                if (eng_done) begin
                    rdata_d = eng_rx;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                rvalid0_d = ~owner_q;
                rvalid1_d = owner_q;
                if (last_f_q) begin
                    // Close the frame: done and the final rvalid appear in the
                    // same cycle cs_n goes high.
                    cs_n_d   = 1'b1;
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                    grant0_d = 1'b0;
                    grant1_d = 1'b0;
                    cnt_d    = c_gap_load;
                    state_d  = S_GAP;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                cs_n_d   = 1'b1;
                grant0_d = 1'b0;
                grant1_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;   // port 0 wins the first tie
            cnt_q        <= 4'd0;
            last_f_q     <= 1'b0;
            eng_tx_q     <= 8'h00;
            rdata_q      <= 8'h00;
            grant0_q     <= 1'b0;
            grant1_q     <= 1'b0;
            cs_n_q       <= 1'b1;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            last_f_q     <= last_f_d;
            eng_tx_q     <= eng_tx_d;
            rdata_q      <= rdata_d;
            grant0_q     <= grant0_d;
            grant1_q     <= grant1_d;
            cs_n_q       <= cs_n_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign eng_send = w_issue_fire;
    assign wready0  = w_issue_fire & ~owner_q;
    assign wready1  = w_issue_fire &  owner_q;
    // During the send cycle the engine sees the owner's byte directly; the
    // latched copy then holds it stable until eng_done.
    assign eng_tx   = w_issue_fire ? w_own_wdata : eng_tx_q;
    assign rdata    = rdata_q;
    assign grant0   = grant0_q;
    assign grant1   = grant1_q;
    assign cs_n     = cs_n_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;

endmodule
`default_nettype wire
